cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_pkg.sv | 60 ++++++
 rtl/cpu_sequencer_timeout.sv | 42 ++++
 rtl/cpu_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the CPU control sequencer: state encodings,
// opcode values and the opcode-class decoder used by the control unit.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU   = 3'd0,
        CLS_ADDI  = 3'd1,
        CLS_LOAD  = 3'd2,
        CLS_STORE = 3'd3,
        CLS_BEQ   = 3'd4,
        CLS_NOP   = 3'd5,
        CLS_HALT  = 3'd6
    } op_class_e;

    localparam logic [3:0] OP_ADDI  = 4'h8;
    localparam logic [3:0] OP_LOAD  = 4'h9;
    localparam logic [3:0] OP_STORE = 4'hA;
    localparam logic [3:0] OP_BEQ   = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Map a raw 4-bit opcode onto its control class.
    function automatic op_class_e decode_class(input logic [3:0] op);
        op_class_e cls;
        if (op[3] == 1'b0) begin
            cls = CLS_ALU;
        end else begin
            case (op)
                OP_ADDI:  cls = CLS_ADDI;
                OP_LOAD:  cls = CLS_LOAD;
                OP_STORE: cls = CLS_STORE;
                OP_BEQ:   cls = CLS_BEQ;
                OP_HALT:  cls = CLS_HALT;
                default:  cls = CLS_NOP;
            endcase
        end
        return cls;
    endfunction

    // Classes that need a data-memory transaction.
    function automatic logic is_mem_class(input op_class_e cls);
        return (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

    // Classes that write a result into the register file.
    function automatic logic writes_reg(input op_class_e cls);
        return (cls == CLS_ALU) || (cls == CLS_ADDI) || (cls == CLS_LOAD);
    endfunction

endpackage

// File: rtl/cpu_sequencer_timeout.sv
// MEM-state watchdog: counts cycles spent waiting for a memory ack and
// flags the final permitted cycle so the sequencer can divert to FAULT.
module seq_timeout_counter #(
    parameter int unsigned LIMIT = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    // Count value of the last allowed MEM cycle (first cycle reads 0).
    localparam logic [7:0] LAST_CYCLE = 8'(LIMIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear outside MEM, advance while waiting, hold once expired.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST_CYCLE);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer. Walks FETCH/DECODE/EXEC/(MEM)/WB per
// instruction, captures the opcode at DECODE and the compare flag at EXEC,
// and drives every control output from registers.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic [3:0] opcode,
    input  logic       compare,
    input  logic       mem_ack,
    output logic       ir_load,
    output logic       alu_en,
    output logic       mem_req,
    output logic       mem_we,
    output logic       reg_write,
    output logic       pc_en,
    output logic       branch_taken,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] instr_count
);

    state_e     state_q;
    state_e     state_d;
    logic [3:0] op_q;
    logic [3:0] op_d;
    logic       cmp_q;
    logic       cmp_d;
    logic [7:0] count_q;
    op_class_e  cls_q;
    op_class_e  cls_d;

    logic ir_load_q;
    logic alu_en_q;
    logic mem_req_q;
    logic mem_we_q;
    logic reg_write_q;
    logic pc_en_q;
    logic branch_q;
    logic halted_q;
    logic fault_q;

    logic tmo_clear_s;
    logic tmo_en_s;
    logic tmo_expired_s;

    assign cls_q = decode_class(op_q);
    assign cls_d = decode_class(op_d);

    assign tmo_clear_s = (state_q != ST_MEM);
    assign tmo_en_s    = (state_q == ST_MEM);

    seq_timeout_counter #(
        .LIMIT(MEM_TIMEOUT)
    ) u_timeout (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (tmo_clear_s),
        .enable_i (tmo_en_s),
        .expired_o(tmo_expired_s)
    );

    // Next-state logic plus opcode/compare capture; after DECODE only op_q steers.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cmp_d   = cmp_q;
        case (state_q)
            ST_IDLE: begin
                if (run || step) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                op_d = opcode;
                if (decode_class(opcode) == CLS_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                cmp_d = compare;
                if (is_mem_class(cls_q)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                // An ack in the last allowed cycle still completes the access.
                if (mem_ack) begin
                    state_d = ST_WB;
                end else if (tmo_expired_s) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                if (run) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // State, captured operands, retire counter and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 4'h0;
            cmp_q       <= 1'b0;
            count_q     <= 8'd0;
            ir_load_q   <= 1'b0;
            alu_en_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            reg_write_q <= 1'b0;
            pc_en_q     <= 1'b0;
            branch_q    <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cmp_q   <= cmp_d;
            // An instruction retires on the edge that leaves WB.
            if (state_q == ST_WB) begin
                count_q <= count_q + 8'd1;
            end else begin
                count_q <= count_q;
            end
            ir_load_q   <= (state_d == ST_FETCH);
            alu_en_q    <= (state_d == ST_EXEC);
            mem_req_q   <= (state_d == ST_MEM);
            mem_we_q    <= (state_d == ST_MEM) && (cls_d == CLS_STORE);
            reg_write_q <= (state_d == ST_WB) && writes_reg(cls_d);
            pc_en_q     <= (state_d == ST_WB);
            branch_q    <= (state_d == ST_WB) && (cls_d == CLS_BEQ) && cmp_d;
            halted_q    <= (state_d == ST_HALT);
            fault_q     <= (state_d == ST_FAULT);
        end
    end

    assign state        = state_q;
    assign instr_count  = count_q;
    assign ir_load      = ir_load_q;
    assign alu_en       = alu_en_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign reg_write    = reg_write_q;
    assign pc_en        = pc_en_q;
    assign branch_taken = branch_q;
    assign halted       = halted_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: hand-computed state/output sequences
// for ALU, branch, load, store timeout, halt, final-cycle ack, reset and wrap.
module tb_cpu_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic       step;
    logic [3:0] opcode;
    logic       compare;
    logic       mem_ack;
    logic       ir_load;
    logic       alu_en;
    logic       mem_req;
    logic       mem_we;
    logic       reg_write;
    logic       pc_en;
    logic       branch_taken;
    logic       halted;
    logic       fault;
    logic [2:0] state;
    logic [7:0] instr_count;
    logic [8:0] outs;

    int errors = 0;
    int checks = 0;

    // Output vector bits: ir_load alu_en mem_req mem_we reg_write pc_en branch halted fault
    localparam logic [8:0] O_NONE  = 9'h000;
    localparam logic [8:0] O_FETCH = 9'h100;
    localparam logic [8:0] O_EXEC  = 9'h080;
    localparam logic [8:0] O_LOAD  = 9'h040;
    localparam logic [8:0] O_STORE = 9'h060;
    localparam logic [8:0] O_WB_RW = 9'h018;
    localparam logic [8:0] O_WB    = 9'h008;
    localparam logic [8:0] O_WB_BR = 9'h00C;
    localparam logic [8:0] O_HALT  = 9'h002;
    localparam logic [8:0] O_FAULT = 9'h001;

    assign outs = {ir_load, alu_en, mem_req, mem_we, reg_write, pc_en,
                   branch_taken, halted, fault};

    cpu_sequencer #(.MEM_TIMEOUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step        (step),
        .opcode      (opcode),
        .compare     (compare),
        .mem_ack     (mem_ack),
        .ir_load     (ir_load),
        .alu_en      (alu_en),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .reg_write   (reg_write),
        .pc_en       (pc_en),
        .branch_taken(branch_taken),
        .halted      (halted),
        .fault       (fault),
        .state       (state),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input string tag, input logic [2:0] exp_state, input logic [8:0] exp_outs);
        chk({tag, "_state"}, {13'd0, state}, {13'd0, exp_state});
        chk({tag, "_outs"}, {7'd0, outs}, {7'd0, exp_outs});
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0; opcode = 4'h0; compare = 1'b0; mem_ack = 1'b0;
        tick(); tick();
        cyc("reset", 3'd0, O_NONE);
        chk("reset_cnt", {8'd0, instr_count}, 16'd0);

        // Free-running ALU instructions: FETCH, DECODE, EXEC, WB repeating.
        rst = 1'b0; run = 1'b1; opcode = 4'h1;
        for (int it = 0; it < 2; it++) begin
            tick(); cyc("alu_fetch", 3'd1, O_FETCH);
            tick(); cyc("alu_decode", 3'd2, O_NONE);
            tick(); cyc("alu_exec", 3'd3, O_EXEC);
            tick(); cyc("alu_wb", 3'd5, O_WB_RW);
        end
        tick(); cyc("alu_refetch", 3'd1, O_FETCH);
        chk("alu_cnt2", {8'd0, instr_count}, 16'd2);

        // Drop run mid-instruction: completes then idles.
        run = 1'b0;
        tick(); tick(); tick(); cyc("stop_wb", 3'd5, O_WB_RW);
        tick(); cyc("stop_idle", 3'd0, O_NONE);
        chk("stop_cnt3", {8'd0, instr_count}, 16'd3);

        // Single-step BEQ with compare=1; opcode changes after DECODE ignored.
        opcode = 4'hB; compare = 1'b1; step = 1'b1;
        tick(); cyc("beq_fetch", 3'd1, O_FETCH);
        step = 1'b0;
        tick(); tick(); cyc("beq_exec", 3'd3, O_EXEC);
        opcode = 4'h1;
        tick(); cyc("beq_wb", 3'd5, O_WB_BR);
        compare = 1'b0;
        tick(); cyc("beq_idle", 3'd0, O_NONE);
        chk("beq_cnt4", {8'd0, instr_count}, 16'd4);

        // LOAD with ack in the third MEM cycle; late opcode switch to STORE ignored.
        opcode = 4'h9; step = 1'b1;
        tick(); step = 1'b0;
        tick(); tick(); cyc("ld_exec", 3'd3, O_EXEC);
        opcode = 4'hA;
        tick(); cyc("ld_mem1", 3'd4, O_LOAD);
        tick(); cyc("ld_mem2", 3'd4, O_LOAD);
        tick(); cyc("ld_mem3", 3'd4, O_LOAD);
        mem_ack = 1'b1;
        tick(); cyc("ld_wb", 3'd5, O_WB_RW);
        mem_ack = 1'b0;
        tick(); cyc("ld_idle", 3'd0, O_NONE);
        chk("ld_cnt5", {8'd0, instr_count}, 16'd5);

        // STORE with no ack: eight MEM cycles, then absorbing FAULT.
        opcode = 4'hA; step = 1'b1;
        tick(); step = 1'b0;
        tick(); tick();
        for (int i = 0; i < 8; i++) begin
            tick(); cyc("st_mem", 3'd4, O_STORE);
        end
        tick(); cyc("st_fault", 3'd7, O_FAULT);
        run = 1'b1; step = 1'b1; mem_ack = 1'b1;
        tick(); tick(); cyc("st_fault_hold", 3'd7, O_FAULT);
        chk("st_cnt5", {8'd0, instr_count}, 16'd5);
        run = 1'b0; step = 1'b0; mem_ack = 1'b0; rst = 1'b1;
        tick(); cyc("fault_rst", 3'd0, O_NONE);
        chk("fault_rst_cnt", {8'd0, instr_count}, 16'd0);
        rst = 1'b0;

        // HALT: absorbing, no pc_en, count unchanged.
        opcode = 4'hF; run = 1'b1;
        tick(); tick();
        tick(); cyc("halt", 3'd6, O_HALT);
        tick(); tick(); tick(); cyc("halt_hold", 3'd6, O_HALT);
        chk("halt_cnt", {8'd0, instr_count}, 16'd0);
        rst = 1'b1; run = 1'b0;
        tick(); cyc("halt_rst", 3'd0, O_NONE);
        rst = 1'b0;

        // STORE acked in the eighth (final) MEM cycle still completes.
        opcode = 4'hA; step = 1'b1;
        tick(); step = 1'b0;
        tick(); tick();
        tick(); cyc("last_mem1", 3'd4, O_STORE);
        for (int i = 0; i < 7; i++) tick();
        cyc("last_mem8", 3'd4, O_STORE);
        mem_ack = 1'b1;
        tick(); cyc("last_wb", 3'd5, O_WB);
        mem_ack = 1'b0;
        tick(); cyc("last_idle", 3'd0, O_NONE);
        chk("last_cnt1", {8'd0, instr_count}, 16'd1);

        // Reach 255 retired instructions, then reset in the middle of MEM.
        rst = 1'b1; tick(); rst = 1'b0;
        run = 1'b1; opcode = 4'h1;
        for (int i = 0; i < 1100 && instr_count != 8'd255; i++) tick();
        chk("cnt255", {8'd0, instr_count}, 16'd255);
        chk("cnt255_state", {13'd0, state}, 16'd1);
        opcode = 4'h9; run = 1'b0;
        tick(); tick();
        tick(); cyc("rst_mem", 3'd4, O_LOAD);
        rst = 1'b1;
        tick(); cyc("rst_mid_mem", 3'd0, O_NONE);
        chk("rst_mid_mem_cnt", {8'd0, instr_count}, 16'd0);

        // Counter wraps 255 -> 0 on the next retired instruction.
        rst = 1'b0; run = 1'b1; opcode = 4'h1;
        for (int i = 0; i < 1100 && instr_count != 8'd255; i++) tick();
        chk("wrap_pre", {8'd0, instr_count}, 16'd255);
        tick(); tick(); tick(); cyc("wrap_wb", 3'd5, O_WB_RW);
        tick(); cyc("wrap_fetch", 3'd1, O_FETCH);
        chk("wrap_cnt0", {8'd0, instr_count}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
